// File: rtl/cpl_arb_pkg.sv
// cpl_arb_pkg: tag packing and counter helpers shared by the completion enqueue arbiter
package cpl_arb_pkg;
  function automatic int port_idx_w(input int ports);
    return (ports < 2) ? 1 : $clog2(ports);
  endfunction
  function automatic logic [31:0] make_tag(input logic [31:0] port, input logic [31:0] local_tag, input int lw);
    return (port << lw) | local_tag;
  endfunction
  function automatic logic [31:0] tag_port(input logic [31:0] tag, input int lw);
    return tag >> lw;
  endfunction
  function automatic logic [31:0] tag_local(input logic [31:0] tag, input int lw);
    return tag & ((32'd1 << lw) - 32'd1);
  endfunction
  function automatic logic [31:0] cnt_next(input logic [31:0] cnt, input logic inc, input logic dec);
    return (inc && !dec) ? cnt + 32'd1 : (dec && !inc && cnt != 32'd0) ? cnt - 32'd1 : cnt;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting at a rotating pointer, advanced past the winner on adv
module rr_arbiter
  import cpl_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = port_idx_w(N)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
  assign any = found;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (adv && found) ptr <= (int'(idx) == N - 1) ? '0 : idx + IW'(1);
endmodule

// File: rtl/cpl_enqueue_arbiter.sv
// cpl_enqueue_arbiter: shares one completion-queue enqueue path among PORTS requesters
module cpl_enqueue_arbiter
  import cpl_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int PORT_TAG_WIDTH = 6,
  parameter int REQ_TAG_WIDTH = port_idx_w(PORTS) + PORT_TAG_WIDTH,
  parameter int OP_TAG_WIDTH = 8,
  parameter int QUEUE_PTR_WIDTH = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int MAX_OUTSTANDING = 8
)(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0]   s_req_queue,
  input  logic [PORTS*PORT_TAG_WIDTH-1:0]      s_req_tag,
  input  logic [PORTS-1:0]                     s_req_valid,
  output logic [PORTS-1:0]                     s_req_ready,
  output logic [PORTS*QUEUE_INDEX_WIDTH-1:0]   m_resp_queue,
  output logic [PORTS*QUEUE_PTR_WIDTH-1:0]     m_resp_ptr,
  output logic [PORTS-1:0]                     m_resp_phase,
  output logic [PORTS*ADDR_WIDTH-1:0]          m_resp_addr,
  output logic [PORTS*PORT_TAG_WIDTH-1:0]      m_resp_tag,
  output logic [PORTS*OP_TAG_WIDTH-1:0]        m_resp_op_tag,
  output logic [PORTS-1:0]                     m_resp_full,
  output logic [PORTS-1:0]                     m_resp_error,
  output logic [PORTS-1:0]                     m_resp_valid,
  input  logic [PORTS-1:0]                     m_resp_ready,
  input  logic [PORTS*OP_TAG_WIDTH-1:0]        s_commit_op_tag,
  input  logic [PORTS-1:0]                     s_commit_valid,
  output logic [PORTS-1:0]                     s_commit_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0]         m_axis_enqueue_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]             m_axis_enqueue_req_tag,
  output logic                                 m_axis_enqueue_req_valid,
  input  logic                                 m_axis_enqueue_req_ready,
  input  logic [QUEUE_INDEX_WIDTH-1:0]         s_axis_enqueue_resp_queue,
  input  logic [QUEUE_PTR_WIDTH-1:0]           s_axis_enqueue_resp_ptr,
  input  logic                                 s_axis_enqueue_resp_phase,
  input  logic [ADDR_WIDTH-1:0]                s_axis_enqueue_resp_addr,
  input  logic [REQ_TAG_WIDTH-1:0]             s_axis_enqueue_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]              s_axis_enqueue_resp_op_tag,
  input  logic                                 s_axis_enqueue_resp_full,
  input  logic                                 s_axis_enqueue_resp_error,
  input  logic                                 s_axis_enqueue_resp_valid,
  output logic                                 s_axis_enqueue_resp_ready,
  output logic [OP_TAG_WIDTH-1:0]              m_axis_enqueue_commit_op_tag,
  output logic                                 m_axis_enqueue_commit_valid,
  input  logic                                 m_axis_enqueue_commit_ready,
  output logic                                 bad_tag
);
  localparam int QW = QUEUE_INDEX_WIDTH;
  localparam int TW = PORT_TAG_WIDTH;
  localparam int OW = OP_TAG_WIDTH;
  localparam int PW = QUEUE_PTR_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int IW = port_idx_w(PORTS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] cnt [PORTS];
  logic [PORTS-1:0] elig, req_gnt, cmt_gnt, inc, dec;
  logic [IW-1:0] req_idx, cmt_idx;
  logic req_any, cmt_any, req_load, cmt_load, rbad;
  logic [31:0] rport;
  always_comb begin
    elig = '0;
    for (int p = 0; p < PORTS; p++) elig[p] = s_req_valid[p] && (cnt[p] < CW'(MAX_OUTSTANDING));
  end
  rr_arbiter #(.N(PORTS)) u_req_arb (
    .clk(clk), .rst_n(rst_n), .req(elig), .adv(req_load),
    .grant(req_gnt), .idx(req_idx), .any(req_any)
  );
  rr_arbiter #(.N(PORTS)) u_cmt_arb (
    .clk(clk), .rst_n(rst_n), .req(s_commit_valid), .adv(cmt_load),
    .grant(cmt_gnt), .idx(cmt_idx), .any(cmt_any)
  );
  assign req_load = !m_axis_enqueue_req_valid || m_axis_enqueue_req_ready;
  assign cmt_load = !m_axis_enqueue_commit_valid || m_axis_enqueue_commit_ready;
  assign s_req_ready = req_load ? req_gnt : '0;
  assign s_commit_ready = cmt_load ? cmt_gnt : '0;
  assign inc = s_req_ready & s_req_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_axis_enqueue_req_valid <= 1'b0;
      m_axis_enqueue_req_queue <= '0;
      m_axis_enqueue_req_tag <= '0;
    end else if (req_load) begin
      m_axis_enqueue_req_valid <= req_any;
      if (req_any) begin
        m_axis_enqueue_req_queue <= s_req_queue[int'(req_idx)*QW +: QW];
        m_axis_enqueue_req_tag <= REQ_TAG_WIDTH'(make_tag(32'(req_idx), 32'(s_req_tag[int'(req_idx)*TW +: TW]), TW));
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_axis_enqueue_commit_valid <= 1'b0;
      m_axis_enqueue_commit_op_tag <= '0;
    end else if (cmt_load) begin
      m_axis_enqueue_commit_valid <= cmt_any;
      if (cmt_any) m_axis_enqueue_commit_op_tag <= s_commit_op_tag[int'(cmt_idx)*OW +: OW];
    end
  // Out-of-range port indices are swallowed so a corrupt tag cannot wedge the manager.
  assign rport = tag_port(32'(s_axis_enqueue_resp_tag), TW);
  assign rbad = rport >= 32'(PORTS);
  assign s_axis_enqueue_resp_ready = rbad || m_resp_ready[rport[IW-1:0]];
  always_comb begin
    m_resp_valid = '0;
    m_resp_queue = '0;
    m_resp_ptr = '0;
    m_resp_phase = '0;
    m_resp_addr = '0;
    m_resp_tag = '0;
    m_resp_op_tag = '0;
    m_resp_full = '0;
    m_resp_error = '0;
    for (int p = 0; p < PORTS; p++)
      if (!rbad && rport == 32'(p)) begin
        m_resp_valid[p] = s_axis_enqueue_resp_valid;
        m_resp_queue[p*QW +: QW] = s_axis_enqueue_resp_queue;
        m_resp_ptr[p*PW +: PW] = s_axis_enqueue_resp_ptr;
        m_resp_phase[p] = s_axis_enqueue_resp_phase;
        m_resp_addr[p*AW +: AW] = s_axis_enqueue_resp_addr;
        m_resp_tag[p*TW +: TW] = TW'(tag_local(32'(s_axis_enqueue_resp_tag), TW));
        m_resp_op_tag[p*OW +: OW] = s_axis_enqueue_resp_op_tag;
        m_resp_full[p] = s_axis_enqueue_resp_full;
        m_resp_error[p] = s_axis_enqueue_resp_error;
      end
  end
  assign dec = m_resp_valid & m_resp_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bad_tag <= 1'b0;
      for (int p = 0; p < PORTS; p++) cnt[p] <= '0;
    end else begin
      bad_tag <= s_axis_enqueue_resp_valid && rbad;
      for (int p = 0; p < PORTS; p++) cnt[p] <= CW'(cnt_next(32'(cnt[p]), inc[p], dec[p]));
    end
endmodule
